// File: rtl/tlb_page_walker.sv
// Two-level hardware page table walker feeding one TLB update port.
// Define TLB_WALKER_STATS_EN to build the walk/fault statistics counters.
module tlb_page_walker #(
  parameter int ASID_WIDTH    = 8,
  parameter int PAGE_NUM_BITS = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     walk_req_en,
  input  logic [PAGE_NUM_BITS-1:0] walk_vpage_idx,
  input  logic [ASID_WIDTH-1:0]    walk_asid,
  input  logic                     walk_cancel,
  input  logic [31:0]              page_dir_base,
  output logic                     walk_busy,
  output logic                     walk_fault,
  output logic                     mem_read_en,
  output logic [31:0]              mem_read_addr,
  input  logic                     mem_read_ack,
  input  logic [31:0]              mem_read_data,
  output logic                     tlb_update_en,
  output logic [PAGE_NUM_BITS-1:0] tlb_update_vpage_idx,
  output logic [ASID_WIDTH-1:0]    tlb_update_asid,
  output logic [PAGE_NUM_BITS-1:0] tlb_update_ppage_idx,
  output logic                     tlb_update_present,
  output logic                     tlb_update_exe_writable,
  output logic                     tlb_update_supervisor,
  output logic                     tlb_update_global,
  output logic [31:0]              walk_count,
  output logic [31:0]              fault_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ_PDE,
    READ_PTE,
    UPDATE,
    FAULT,
    DRAIN
  } state_t;

  state_t                   state;
  logic [PAGE_NUM_BITS-1:0] vpage_q;
  logic [ASID_WIDTH-1:0]    asid_q;
  logic                     upd_q;
  logic                     fault_q;
  logic                     unused_bits;

  assign unused_bits = ^mem_read_data[11:4];

  // A late cancel still kills the pulse already sitting in the flop.
  assign tlb_update_en        = upd_q & ~walk_cancel;
  assign walk_fault           = fault_q & ~walk_cancel;
  assign tlb_update_vpage_idx = vpage_q;
  assign tlb_update_asid      = asid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      vpage_q                 <= '0;
      asid_q                  <= '0;
      upd_q                   <= 1'b0;
      fault_q                 <= 1'b0;
      walk_busy               <= 1'b0;
      mem_read_en             <= 1'b0;
      mem_read_addr           <= '0;
      tlb_update_ppage_idx    <= '0;
      tlb_update_present      <= 1'b0;
      tlb_update_exe_writable <= 1'b0;
      tlb_update_supervisor   <= 1'b0;
      tlb_update_global       <= 1'b0;
    end else begin
      upd_q   <= 1'b0;
      fault_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (walk_req_en) begin
            vpage_q       <= walk_vpage_idx;
            asid_q        <= walk_asid;
            walk_busy     <= 1'b1;
            mem_read_en   <= 1'b1;
            mem_read_addr <= {page_dir_base[31:12],
                              walk_vpage_idx[19:10], 2'b00};
            state         <= READ_PDE;
          end
        end
        READ_PDE: begin
          if (walk_cancel) begin
            if (mem_read_ack) begin
              mem_read_en <= 1'b0;
              walk_busy   <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (mem_read_ack) begin
            if (!mem_read_data[0]) begin
              mem_read_en <= 1'b0;
              fault_q     <= 1'b1;
              state       <= FAULT;
            end else begin
              mem_read_addr <= {mem_read_data[31:12],
                                vpage_q[9:0], 2'b00};
              state         <= READ_PTE;
            end
          end
        end
        READ_PTE: begin
          if (walk_cancel) begin
            if (mem_read_ack) begin
              mem_read_en <= 1'b0;
              walk_busy   <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (mem_read_ack) begin
            mem_read_en <= 1'b0;
            if (!mem_read_data[0]) begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              upd_q                   <= 1'b1;
              tlb_update_ppage_idx    <= mem_read_data[31:12];
              tlb_update_present      <= 1'b1;
              tlb_update_exe_writable <= mem_read_data[1];
              tlb_update_supervisor   <= mem_read_data[2];
              tlb_update_global       <= mem_read_data[3];
              state                   <= UPDATE;
            end
          end
        end
        UPDATE, FAULT: begin
          walk_busy <= 1'b0;
          state     <= IDLE;
        end
        DRAIN: begin
          if (mem_read_ack) begin
            mem_read_en <= 1'b0;
            walk_busy   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TLB_WALKER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      walk_count  <= '0;
      fault_count <= '0;
    end else begin
      if (state == IDLE && walk_req_en)
        walk_count <= walk_count + 32'd1;
      if (walk_fault)
        fault_count <= fault_count + 32'd1;
    end
  end
`else
  assign walk_count  = '0;
  assign fault_count = '0;
`endif

  // A second request while a walk is in flight is dropped by the FSM.
  a_no_req_busy: assert property (
    @(posedge clk) disable iff (reset) !(walk_req_en && walk_busy)
  );

endmodule

// File: tb/tb_tlb_page_walker.sv
// Directed bench for tlb_page_walker with a small memory responder.
module tb_tlb_page_walker;

`ifdef TLB_WALKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        walk_req_en = 1'b0;
  logic [19:0] walk_vpage_idx = '0;
  logic [7:0]  walk_asid = '0;
  logic        walk_cancel = 1'b0;
  logic [31:0] page_dir_base = '0;
  logic        walk_busy, walk_fault, mem_read_en;
  logic [31:0] mem_read_addr;
  logic        mem_read_ack = 1'b0;
  logic [31:0] mem_read_data = '0;
  logic        tlb_update_en;
  logic [19:0] tlb_update_vpage_idx, tlb_update_ppage_idx;
  logic [7:0]  tlb_update_asid;
  logic        tlb_update_present, tlb_update_exe_writable;
  logic        tlb_update_supervisor, tlb_update_global;
  logic [31:0] walk_count, fault_count;

  tlb_page_walker dut (
    .clk                     (clk),
    .reset                   (reset),
    .walk_req_en             (walk_req_en),
    .walk_vpage_idx          (walk_vpage_idx),
    .walk_asid               (walk_asid),
    .walk_cancel             (walk_cancel),
    .page_dir_base           (page_dir_base),
    .walk_busy               (walk_busy),
    .walk_fault              (walk_fault),
    .mem_read_en             (mem_read_en),
    .mem_read_addr           (mem_read_addr),
    .mem_read_ack            (mem_read_ack),
    .mem_read_data           (mem_read_data),
    .tlb_update_en           (tlb_update_en),
    .tlb_update_vpage_idx    (tlb_update_vpage_idx),
    .tlb_update_asid         (tlb_update_asid),
    .tlb_update_ppage_idx    (tlb_update_ppage_idx),
    .tlb_update_present      (tlb_update_present),
    .tlb_update_exe_writable (tlb_update_exe_writable),
    .tlb_update_supervisor   (tlb_update_supervisor),
    .tlb_update_global       (tlb_update_global),
    .walk_count              (walk_count),
    .fault_count             (fault_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int ncyc = 0;
  int wait_cycles = 0;
  int ack_ctr = 0;
  bit fresh = 1'b1;
  int upd_n = 0;
  int flt_n = 0;
  int upd_cyc = 0;
  int flt_cyc = 0;
  int t0 = 0;
  bit addr_bad = 1'b0;
  bit excl_bad = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [19:0] up_pp, up_vp;
  logic [7:0]  up_asid;
  logic [3:0]  up_attr;
  logic [31:0] rd_addr[$];
  logic [31:0] mem [logic [31:0]];

  // Monitor plus memory: the first read acks one cycle after mem_read_en
  // rises, a read issued right after an ack is answered a cycle sooner.
  always @(negedge clk) begin
    ncyc++;
    if (tlb_update_en) begin
      upd_n++;
      upd_cyc = ncyc;
      up_pp   = tlb_update_ppage_idx;
      up_vp   = tlb_update_vpage_idx;
      up_asid = tlb_update_asid;
      up_attr = {tlb_update_global, tlb_update_supervisor,
                 tlb_update_exe_writable, tlb_update_present};
    end
    if (walk_fault) begin
      flt_n++;
      flt_cyc = ncyc;
    end
    if ((tlb_update_en && walk_fault) ||
        ((tlb_update_en || walk_fault) && !walk_busy))
      excl_bad = 1'b1;
    if (mem_read_ack) begin
      mem_read_ack = 1'b0;
      ack_ctr = 1;
      fresh = 1'b1;
    end
    if (reset || !mem_read_en) begin
      mem_read_ack = 1'b0;
      ack_ctr = 0;
      fresh = 1'b1;
    end else begin
      if (!fresh && mem_read_addr != prev_addr) addr_bad = 1'b1;
      fresh = 1'b0;
      prev_addr = mem_read_addr;
      ack_ctr++;
      if (ack_ctr >= wait_cycles + 2) begin
        mem_read_ack = 1'b1;
        mem_read_data = mem.exists(mem_read_addr) ? mem[mem_read_addr] : '0;
        rd_addr.push_back(mem_read_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [19:0] vp, input logic [7:0] asid);
    walk_vpage_idx = vp;
    walk_asid = asid;
    walk_req_en = 1'b1;
    t0 = ncyc;
    tick(1);
    walk_req_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (walk_busy && k < 100) begin
      tick(1);
      k++;
    end
    check(tag, 32'(k < 100), 32'd1);
    tick(1);
  endtask

  int u0, f0, r0;

  task automatic snap();
    u0 = upd_n;
    f0 = flt_n;
    r0 = rd_addr.size();
  endtask

  initial begin
    mem[32'h0001_0004] = 32'h0002_0001;
    mem[32'h0002_0004] = 32'h0ABC_D00F;
    mem[32'h0001_000C] = 32'h0003_0001;
    mem[32'h0003_000C] = 32'h0ABC_D000;
    mem[32'h0001_0008] = 32'h0002_0000;
    page_dir_base = 32'h0001_0000;

    tick(2);
    check("rst_busy", 32'(walk_busy), 0);
    check("rst_rd_en", 32'(mem_read_en), 0);
    check("rst_addr", mem_read_addr, 0);
    check("rst_upd", 32'(tlb_update_en), 0);
    check("rst_flt", 32'(walk_fault), 0);
    check("rst_wcnt", walk_count, 0);
    reset = 1'b0;
    tick(2);

    snap();
    start(20'h00401, 8'h5A);
    check("busy_set", 32'(walk_busy), 1);
    wait_idle("hit_done");
    check("hit_upd_n", 32'(upd_n - u0), 1);
    check("hit_flt_n", 32'(flt_n - f0), 0);
    check("hit_lat", 32'(upd_cyc - t0), 4);
    check("hit_ppage", 32'(up_pp), 32'h0ABCD);
    check("hit_attr", 32'(up_attr), 32'hF);
    check("hit_vpage", 32'(up_vp), 32'h00401);
    check("hit_asid", 32'(up_asid), 32'h5A);
    check("hit_reads", 32'(rd_addr.size() - r0), 2);
    check("pde_addr", rd_addr[r0], 32'h0001_0004);
    check("pte_addr", rd_addr[r0+1], 32'h0002_0004);
    check("hit_wcnt", walk_count, STATS ? 32'd1 : 32'd0);

    snap();
    start(20'h00C03, 8'h11);
    wait_idle("pte_np_done");
    check("pte_np_flt", 32'(flt_n - f0), 1);
    check("pte_np_upd", 32'(upd_n - u0), 0);
    check("pte_np_lat", 32'(flt_cyc - t0), 4);
    check("pte_np_reads", 32'(rd_addr.size() - r0), 2);
    check("pte_np_fcnt", fault_count, STATS ? 32'd1 : 32'd0);

    snap();
    start(20'h00802, 8'h22);
    wait_idle("pde_np_done");
    check("pde_np_flt", 32'(flt_n - f0), 1);
    check("pde_np_upd", 32'(upd_n - u0), 0);
    check("pde_np_lat", 32'(flt_cyc - t0), 3);
    check("pde_np_reads", 32'(rd_addr.size() - r0), 1);

    snap();
    wait_cycles = 5;
    start(20'h00401, 8'h33);
    wait_idle("ws_done");
    check("ws_upd_n", 32'(upd_n - u0), 1);
    check("ws_lat", 32'(upd_cyc - t0), 14);
    check("ws_asid", 32'(up_asid), 32'h33);

    snap();
    wait_cycles = 3;
    start(20'h00401, 8'h44);
    tick(5);
    walk_cancel = 1'b1;
    tick(1);
    walk_cancel = 1'b0;
    check("cx_rd_en", 32'(mem_read_en), 1);
    check("cx_addr", mem_read_addr, 32'h0002_0004);
    tick(1);
    check("cx_busy", 32'(walk_busy), 1);
    tick(2);
    check("cx_idle", 32'(walk_busy), 0);
    check("cx_rd_off", 32'(mem_read_en), 0);
    check("cx_upd", 32'(upd_n - u0), 0);
    check("cx_flt", 32'(flt_n - f0), 0);
    check("cx_reads", 32'(rd_addr.size() - r0), 2);
    check("cx_wcnt", walk_count, STATS ? 32'd5 : 32'd0);
    check("cx_fcnt", fault_count, STATS ? 32'd2 : 32'd0);

    wait_cycles = 0;
    start(20'h00401, 8'h55);
    reset = 1'b1;
    #1;
    check("mr_busy", 32'(walk_busy), 0);
    check("mr_rd_en", 32'(mem_read_en), 0);
    check("mr_addr", mem_read_addr, 0);
    check("mr_wcnt", walk_count, 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    snap();
    walk_cancel = 1'b1;
    start(20'h00401, 8'h66);
    walk_cancel = 1'b0;
    wait_idle("post_done");
    check("post_upd_n", 32'(upd_n - u0), 1);
    check("post_lat", 32'(upd_cyc - t0), 4);
    check("post_asid", 32'(up_asid), 32'h66);
    check("post_wcnt", walk_count, STATS ? 32'd1 : 32'd0);

    check("addr_stable", 32'(addr_bad), 0);
    check("pulse_excl", 32'(excl_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
